gray_hot_decoder: RTL and testbench

Registered decoder that reverses the Gray/one-hot encoder: accepts a 7-bit one-hot code (or a 3-bit Gray code in Gray mode) and returns the 3-bit binary value. Each accepted code is checked for legality; illegal codes raise a per-sample error and count toward a fault lock-out that stops output until software clears it. It sits on the receive side of any link carrying encoder output.

---
 rtl/gray_hot_decoder.sv | 102 ++++++++++
 tb/tb_gray_hot_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/gray_hot_decoder.sv
// Registered one-hot/Gray to binary decoder with legality check and fault lock-out; 1-cycle latency, no backpressure.
// Optional macro ERR_CNT_EN builds the saturating illegal-sample counter (err_cnt tied to 0 otherwise).
module gray_hot_decoder #(
  parameter bit USE_GRAY  = 1'b0,
  parameter int ERR_LIMIT = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [6:0]       in_code,
  input  logic             clr,
  output logic             out_valid,
  output logic [2:0]       out_bin,
  output logic             out_err,
  output logic             err_sticky,
  output logic             fault,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int CW = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT + 1);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   consec;
  logic [2:0]      dec_bin;
  logic            dec_ok;
  logic            accept;

  always_comb begin
    dec_bin = 3'd0;
    dec_ok  = 1'b0;
    if (USE_GRAY) begin
      dec_ok = (in_code[6:3] == 4'd0);
      if (dec_ok)
        dec_bin = {in_code[2], in_code[2] ^ in_code[1], in_code[2] ^ in_code[1] ^ in_code[0]};
    end else if (in_code == 7'd0) begin
      dec_ok = 1'b1;
    end else begin
      for (int k = 0; k < 7; k++) begin
        if (in_code == 7'(1 << k)) begin
          dec_ok  = 1'b1;
          dec_bin = 3'(k + 1);
        end
      end
    end
  end

  // A sample is only taken in RUN and never in a clr cycle.
  assign accept = in_valid && !clr && (state == RUN);
  assign fault  = (state == FAULT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      consec     <= '0;
      out_valid  <= 1'b0;
      out_bin    <= 3'd0;
      out_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clr) begin
        state      <= RUN;
        consec     <= '0;
        err_sticky <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_bin   <= dec_ok ? dec_bin : 3'd0;
        out_err   <= !dec_ok;
        if (dec_ok) begin
          consec <= '0;
        end else begin
          err_sticky <= 1'b1;
          if (consec == CW'(ERR_LIMIT - 1))
            state <= FAULT;
          else
            consec <= consec + 1'b1;
        end
      end
    end
  end

`ifdef ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (clr)
      cnt_q <= '0;
    else if (accept && !dec_ok && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_gray_hot_decoder.sv
// Directed bench for gray_hot_decoder: default one-hot build, Gray build, and a narrow-counter build.
module tb_gray_hot_decoder;

`ifdef ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v0 = 0, clr0 = 0, v1 = 0, clr1 = 0, v2 = 0, clr2 = 0;
  logic [6:0] c0 = 0, c1 = 0, c2 = 0;
  logic       ov0, oe0, st0, f0, ov1, oe1, st1, f1, ov2, oe2, st2, f2;
  logic [2:0] ob0, ob1, ob2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int compared = 0;
  int mismatched = 0;

  gray_hot_decoder #(.USE_GRAY(1'b0), .ERR_LIMIT(3), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_code(c0), .clr(clr0),
    .out_valid(ov0), .out_bin(ob0), .out_err(oe0), .err_sticky(st0), .fault(f0), .err_cnt(cnt0));

  gray_hot_decoder #(.USE_GRAY(1'b1), .ERR_LIMIT(3), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_code(c1), .clr(clr1),
    .out_valid(ov1), .out_bin(ob1), .out_err(oe1), .err_sticky(st1), .fault(f1), .err_cnt(cnt1));

  gray_hot_decoder #(.USE_GRAY(1'b0), .ERR_LIMIT(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_code(c2), .clr(clr2),
    .out_valid(ov2), .out_bin(ob2), .out_err(oe2), .err_sticky(st2), .fault(f2), .err_cnt(cnt2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ecnt(input int n);
    return CNT_ON ? 32'(n) : 32'd0;
  endfunction

  logic [6:0] gcodes [8];

  initial begin
    gcodes = '{7'd0, 7'd1, 7'd3, 7'd2, 7'd6, 7'd7, 7'd5, 7'd4};

    // Reset state
    tick; tick;
    chk("rst_out_valid", ov0, 0);
    chk("rst_out_bin", ob0, 0);
    chk("rst_out_err", oe0, 0);
    chk("rst_sticky", st0, 0);
    chk("rst_fault", f0, 0);
    chk("rst_cnt", cnt0, 0);
    rst = 1'b0;
    tick;

    // One-hot sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      v0 = 1'b1;
      c0 = (i == 0) ? 7'd0 : 7'(1 << (i - 1));
      tick;
      chk($sformatf("sweep_valid_%0d", i), ov0, 1);
      chk($sformatf("sweep_bin_%0d", i), ob0, i);
      chk($sformatf("sweep_err_%0d", i), oe0, 0);
    end
    v0 = 1'b0;
    tick;
    chk("idle_valid", ov0, 0);
    chk("idle_bin_hold", ob0, 7);

    // Illegal one-hot then legal
    v0 = 1'b1; c0 = 7'b000_0011;
    tick;
    chk("ill_valid", ov0, 1);
    chk("ill_bin", ob0, 0);
    chk("ill_err", oe0, 1);
    chk("ill_sticky", st0, 1);
    chk("ill_cnt", cnt0, ecnt(1));
    c0 = 7'b000_0100;
    tick;
    chk("leg_bin", ob0, 3);
    chk("leg_err", oe0, 0);
    chk("leg_sticky", st0, 1);

    // Clear, then non-consecutive errors
    v0 = 1'b0; clr0 = 1'b1;
    tick;
    clr0 = 1'b0;
    chk("clr_sticky", st0, 0);
    chk("clr_cnt", cnt0, 0);
    v0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c0 = (i % 2 == 0) ? 7'b111_1111 : 7'b000_0001;
      tick;
      chk($sformatf("nc_err_%0d", i), oe0, (i % 2 == 0) ? 1 : 0);
    end
    chk("nc_fault", f0, 0);
    chk("nc_cnt", cnt0, ecnt(3));

    // Legal resets the run, then three consecutive illegal codes
    c0 = 7'b000_0010;
    tick;
    chk("pre_fault_bin", ob0, 2);
    c0 = 7'b111_1111;
    tick;
    chk("f1_fault", f0, 0);
    tick;
    chk("f2_fault", f0, 0);
    tick;
    chk("f3_valid", ov0, 1);
    chk("f3_err", oe0, 1);
    chk("f3_fault", f0, 1);
    c0 = 7'b001_0000;
    tick;
    chk("lock_valid_a", ov0, 0);
    tick;
    chk("lock_valid_b", ov0, 0);
    chk("lock_fault", f0, 1);
    chk("lock_cnt", cnt0, ecnt(6));
    c0 = 7'b000_0001; clr0 = 1'b1;
    tick;
    clr0 = 1'b0;
    chk("fclr_fault", f0, 0);
    chk("fclr_cnt", cnt0, 0);
    chk("fclr_drop_valid", ov0, 0);
    c0 = 7'b001_0000;
    tick;
    chk("post_clr_valid", ov0, 1);
    chk("post_clr_bin", ob0, 5);
    v0 = 1'b0;

    // Gray mode
    v1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c1 = gcodes[i];
      tick;
      chk($sformatf("gray_bin_%0d", i), ob1, i);
      chk($sformatf("gray_err_%0d", i), oe1, 0);
    end
    c1 = 7'b000_1000;
    tick;
    chk("gray_ill_err", oe1, 1);
    chk("gray_ill_bin", ob1, 0);
    chk("gray_ill_sticky", st1, 1);
    v1 = 1'b0;

    // Narrow counter saturation
    v2 = 1'b1; c2 = 7'b111_1111;
    for (int i = 1; i <= 5; i++) begin
      tick;
      chk($sformatf("sat_cnt_%0d", i), cnt2, ecnt((i > 3) ? 3 : i));
    end
    chk("sat_fault", f2, 0);
    chk("sat_valid", ov2, 1);

    // Asynchronous reset mid-stream
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_valid", ov2, 0);
    chk("arst_err", oe2, 0);
    chk("arst_sticky", st2, 0);
    chk("arst_cnt", cnt2, 0);
    chk("arst_fault", f2, 0);
    chk("arst_bin0", ob0, 0);
    v2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick;
    chk("arst_no_inflight", ov2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
